// File: rtl/median_window_3x3.sv
// 3x3 neighbourhood generator for the median blur datapath.
// Buffers two raster lines and emits one registered window per interior pixel.
module median_window_3x3 #(
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_pixel,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          px_1,
    output logic [DATA_W-1:0]          px_2,
    output logic [DATA_W-1:0]          px_3,
    output logic [DATA_W-1:0]          px_4,
    output logic [DATA_W-1:0]          px_5,
    output logic [DATA_W-1:0]          px_6,
    output logic [DATA_W-1:0]          px_7,
    output logic [DATA_W-1:0]          px_8,
    output logic [DATA_W-1:0]          px_9,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0]  col, col_nxt, cur_col;
    logic [ROW_W-1:0]  row, row_nxt, cur_row;
    logic              emit, last_pix;

    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;

    logic [DATA_W-1:0] win     [3][3];
    logic [DATA_W-1:0] win_nxt [3][3];

    // Position of the pixel on the input this cycle; SOF forces (0,0)
    always_comb begin
        cur_col = in_sof ? '0 : col;
        cur_row = in_sof ? '0 : row;
        col_nxt = col;
        row_nxt = row;
        if (in_valid) begin
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_nxt = '0;
                row_nxt = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_nxt = cur_col + COL_W'(1);
                row_nxt = cur_row;
            end
        end
    end

    // Rows 0/1 and columns 0/1 never form a complete window
    always_comb begin
        emit     = in_valid && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        last_pix = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
    end

    // Window after this accept: shift left, new right column read before the line write
    always_comb begin
        lb1_rd = lb1[cur_col];
        lb2_rd = lb2[cur_col];
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = lb2_rd;
        win_nxt[1][2] = lb1_rd;
        win_nxt[2][2] = in_pixel;
    end

    // Line buffers and shift array are storage only; no reset
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= in_pixel;
            win          <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            px_1       <= '0;
            px_2       <= '0;
            px_3       <= '0;
            px_4       <= '0;
            px_5       <= '0;
            px_6       <= '0;
            px_7       <= '0;
            px_8       <= '0;
            px_9       <= '0;
        end else begin
            col        <= col_nxt;
            row        <= row_nxt;
            out_valid  <= emit;
            frame_done <= emit && last_pix;
            // Outputs only update with a window, holding otherwise
            if (emit) begin
                out_row <= cur_row - ROW_W'(1);
                out_col <= cur_col - COL_W'(1);
                px_1    <= win_nxt[0][0];
                px_2    <= win_nxt[0][1];
                px_3    <= win_nxt[0][2];
                px_4    <= win_nxt[1][0];
                px_5    <= win_nxt[1][1];
                px_6    <= win_nxt[1][2];
                px_7    <= win_nxt[2][0];
                px_8    <= win_nxt[2][1];
                px_9    <= win_nxt[2][2];
            end
        end
    end

endmodule

// File: tb/tb_median_window_3x3.sv
// Bench for median_window_3x3: a 4x4 instance for directed frames and a 12x9 instance
// for random frames, both checked every cycle against an image-array model.
module tb_median_window_3x3;

    localparam int unsigned SW = 4;
    localparam int unsigned SH = 4;
    localparam int unsigned BW = 12;
    localparam int unsigned BH = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic s_v, s_sof, b_v, b_sof;
    logic [7:0] s_pix, b_pix;
    logic s_ov, s_done, b_ov, b_done;
    logic [8:0][7:0] s_px, b_px;
    logic [1:0] s_row, s_col;
    logic [3:0] b_row, b_col;

    median_window_3x3 #(.IMG_W(SW), .IMG_H(SH), .DATA_W(8)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_v), .in_sof(s_sof), .in_pixel(s_pix),
        .out_valid(s_ov),
        .px_1(s_px[0]), .px_2(s_px[1]), .px_3(s_px[2]),
        .px_4(s_px[3]), .px_5(s_px[4]), .px_6(s_px[5]),
        .px_7(s_px[6]), .px_8(s_px[7]), .px_9(s_px[8]),
        .out_row(s_row), .out_col(s_col), .frame_done(s_done)
    );

    median_window_3x3 #(.IMG_W(BW), .IMG_H(BH), .DATA_W(8)) u_big (
        .clk(clk), .rst(rst), .in_valid(b_v), .in_sof(b_sof), .in_pixel(b_pix),
        .out_valid(b_ov),
        .px_1(b_px[0]), .px_2(b_px[1]), .px_3(b_px[2]),
        .px_4(b_px[3]), .px_5(b_px[4]), .px_6(b_px[5]),
        .px_7(b_px[6]), .px_8(b_px[7]), .px_9(b_px[8]),
        .out_row(b_row), .out_col(b_col), .frame_done(b_done)
    );

    int checks = 0;
    int errors = 0;

    // Model state per instance: whole image array plus expected (held) outputs
    logic [7:0] img   [2][16][16];
    int         m_r   [2];
    int         m_c   [2];
    logic       e_valid [2];
    logic       e_done  [2];
    logic [7:0] e_px  [2][9];
    int         e_row [2];
    int         e_col [2];
    int         n_win [2];
    int         n_exp [2];

    logic       cap_arm;
    logic [7:0] cap_px [9];
    int         cap_row, cap_col;
    logic       nb_check, prev_v;

    function automatic int imw(input int id);
        return (id == 0) ? int'(SW) : int'(BW);
    endfunction

    function automatic int imh(input int id);
        return (id == 0) ? int'(SH) : int'(BH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_r[id] = 0;
            m_c[id] = 0;
            e_valid[id] = 1'b0;
            e_done[id] = 1'b0;
            e_row[id] = 0;
            e_col[id] = 0;
            for (int k = 0; k < 9; k++) e_px[id][k] = 8'h00;
        end
    endtask

    // Place the pixel in the image; a window exists once its bottom-right neighbour arrives
    task automatic model_accept(input int id, input logic sof, input logic [7:0] pix);
        int r, c;
        r = sof ? 0 : m_r[id];
        c = sof ? 0 : m_c[id];
        img[id][r][c] = pix;
        e_valid[id] = (r >= 2) && (c >= 2);
        e_done[id]  = e_valid[id] && (r == imh(id) - 1) && (c == imw(id) - 1);
        if (e_valid[id]) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e_px[id][3*i+j] = img[id][r-2+i][c-2+j];
            e_row[id] = r - 1;
            e_col[id] = c - 1;
            n_exp[id]++;
        end
        c++;
        if (c == imw(id)) begin
            c = 0;
            r = (r + 1) % imh(id);
        end
        m_r[id] = r;
        m_c[id] = c;
    endtask

    task automatic check_out(input int id);
        logic [31:0] v, d, rw, cl;
        logic [7:0]  p [9];
        if (id == 0) begin
            v = 32'(s_ov); d = 32'(s_done); rw = 32'(s_row); cl = 32'(s_col);
            for (int k = 0; k < 9; k++) p[k] = s_px[k];
        end else begin
            v = 32'(b_ov); d = 32'(b_done); rw = 32'(b_row); cl = 32'(b_col);
            for (int k = 0; k < 9; k++) p[k] = b_px[k];
        end
        chk($sformatf("out_valid[%0d]", id), v, 32'(e_valid[id]));
        chk($sformatf("frame_done[%0d]", id), d, 32'(e_done[id]));
        chk($sformatf("out_row[%0d]", id), rw, 32'(e_row[id]));
        chk($sformatf("out_col[%0d]", id), cl, 32'(e_col[id]));
        for (int k = 0; k < 9; k++)
            chk($sformatf("px_%0d[%0d]", k + 1, id), 32'(p[k]), 32'(e_px[id][k]));
        if (v == 32'd1) begin
            n_win[id]++;
            if (id == 0 && cap_arm) begin
                cap_arm = 1'b0;
                cap_px  = p;
                cap_row = int'(rw);
                cap_col = int'(cl);
            end
        end
        if (id == 0 && nb_check) begin
            chk("no_back_to_back", 32'(prev_v && v[0]), 32'd0);
            prev_v = v[0];
        end
    endtask

    // One clock: drive instance id, then update the model and compare just after the edge
    task automatic step(input int id, input logic r_v, input logic v, input logic sof,
                        input logic [7:0] pix);
        rst   = r_v;
        s_v   = (id == 0) && v;  s_sof = (id == 0) && sof;  s_pix = pix;
        b_v   = (id == 1) && v;  b_sof = (id == 1) && sof;  b_pix = pix;
        @(posedge clk);
        #1;
        if (r_v) begin
            model_reset();
        end else begin
            e_valid[1-id] = 1'b0;
            e_done[1-id]  = 1'b0;
            if (v) begin
                model_accept(id, sof, pix);
            end else begin
                e_valid[id] = 1'b0;
                e_done[id]  = 1'b0;
            end
        end
        check_out(id);
    endtask

    task automatic send_small(input logic [7:0] base, input logic gaps, input int npix);
        for (int idx = 0; idx < npix; idx++) begin
            step(0, 1'b0, 1'b1, idx == 0, base + 8'(16 * (idx / 4) + (idx % 4)));
            if (gaps) step(0, 1'b0, 1'b0, 1'b0, 8'hEE);
        end
    endtask

    // Window centred at (1,1) of a frame whose pixel (r,c) is base+16r+c
    task automatic chk_cap(input string tag, input logic [7:0] base);
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s_px%0d", tag, k + 1), 32'(cap_px[k]), 32'(base + 8'(16 * (k / 3) + (k % 3))));
        chk({tag, "_row"}, 32'(cap_row), 32'd1);
        chk({tag, "_col"}, 32'(cap_col), 32'd1);
    endtask

    task automatic send_big(input int abort_at);
        for (int idx = 0; idx < int'(BW * BH); idx++) begin
            if (idx == abort_at) return;
            if ($urandom_range(0, 2) == 0) step(1, 1'b0, 1'b0, 1'b0, 8'($urandom));
            step(1, 1'b0, 1'b1, idx == 0, 8'($urandom));
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        s_v = 1'b0; s_sof = 1'b0; s_pix = '0;
        b_v = 1'b0; b_sof = 1'b0; b_pix = '0;
        cap_arm = 1'b0; nb_check = 1'b0; prev_v = 1'b0;
        n_win[0] = 0; n_win[1] = 0; n_exp[0] = 0; n_exp[1] = 0;
        model_reset();

        step(0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_out(1);

        // Continuous frame
        n0 = n_win[0]; cap_arm = 1'b1;
        send_small(8'h00, 1'b0, 16);
        step(0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("s1_windows", 32'(n_win[0] - n0), 32'd4);
        chk_cap("s1_first", 8'h00);

        // Same frame with gaps
        n0 = n_win[0]; cap_arm = 1'b1; nb_check = 1'b1; prev_v = 1'b0;
        send_small(8'h00, 1'b1, 16);
        nb_check = 1'b0;
        chk("s2_windows", 32'(n_win[0] - n0), 32'd4);
        chk_cap("s2_first", 8'h00);

        // Back-to-back frames, second offset by 0x80
        send_small(8'h00, 1'b0, 16);
        n0 = n_win[0]; cap_arm = 1'b1;
        send_small(8'h80, 1'b0, 16);
        step(0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("s3_windows", 32'(n_win[0] - n0), 32'd4);
        chk_cap("s3_first", 8'h80);

        // Frame A aborted by SOF where (2,1) would be, then frame B
        n0 = n_win[0]; cap_arm = 1'b1;
        send_small(8'h40, 1'b0, 9);
        send_small(8'h00, 1'b0, 16);
        step(0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("s4_windows", 32'(n_win[0] - n0), 32'd4);
        chk_cap("s4_first", 8'h00);

        // Reset while pixel (2,3) is offered, after window (1,1) was emitted
        send_small(8'h30, 1'b0, 11);
        step(0, 1'b1, 1'b1, 1'b0, 8'h63);
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_px5", 32'(s_px[4]), 32'd0);
        n0 = n_win[0]; cap_arm = 1'b1;
        send_small(8'h00, 1'b0, 16);
        step(0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("s5_windows", 32'(n_win[0] - n0), 32'd4);
        chk_cap("s5_first", 8'h00);

        // Random frames on the 12x9 instance
        n0 = n_win[1];
        send_big(-1);
        send_big(-1);
        step(1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("big_two_frames", 32'(n_win[1] - n0), 32'(2 * (BW - 2) * (BH - 2)));
        send_big(int'($urandom_range(20, 80)));
        send_big(-1);
        send_big(-1);
        step(1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("big_vs_model", 32'(n_win[1]), 32'(n_exp[1]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/median_window_3x3.md
Name: median_window_3x3

Overview:
- Upstream feeder for the 3x3 median blur datapath.
- Accepts a raster-order pixel stream, one pixel per accepted cycle, and buffers the two previous image lines.
- Emits a registered 3x3 neighbourhood (px_1..px_9) for every interior pixel, so the combinational median stage can consume one window per cycle.
- Border pixels (first/last row and column) produce no window.

Parameters:
- IMG_W, 640, image width in pixels (>=3)
- IMG_H, 480, image height in lines (>=3)
- DATA_W, 8, pixel width in bits; the median stage requires 8

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  in_pixel is valid this cycle; no backpressure, gaps allowed
- in_sof  input  1  start of frame; qualified by in_valid, marks pixel (0,0)
- in_pixel  input  DATA_W  raster-order pixel
- out_valid  output  1  px_1..px_9, out_row and out_col are valid this cycle
- px_1..px_9  output  DATA_W each  window, row-major: px_1..px_3 top line left→right, px_4..px_6 centre line (px_5 = centre), px_7..px_9 bottom line
- out_row  output  clog2(IMG_H)  row of the centre pixel
- out_col  output  clog2(IMG_W)  column of the centre pixel
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (rst=1 at a clk edge):
  - col and row counters go to 0.
  - out_valid, frame_done, px_1..px_9, out_row and out_col all go to 0.
  - Line buffer RAM contents are not cleared.
- Acceptance: a pixel is accepted on each edge with in_valid=1. Cycles with in_valid=0 change no state, and out_valid=0 on the following cycle.
- Position counters: col counts 0..IMG_W-1. On wrap, col returns to 0 and row increments, counting 0..IMG_H-1. After pixel (IMG_H-1, IMG_W-1), both counters return to 0.
- SOF resync: when in_valid=1 and in_sof=1, the accepted pixel is treated as (0,0) regardless of the counters. After it, col=1 and row=0.
  - An SOF arriving mid-frame aborts the partial frame with no error flag.
  - No window may be emitted from the aborted frame's lines.
- Line buffers: two line buffers, lb1 holding row-1 and lb2 holding row-2, each IMG_W deep and indexed by col. On accept at column c:
  - lb2[c] <= lb1[c] (old value)
  - lb1[c] <= in_pixel
- Window registers: a 3x3 register array. On accept, the columns shift left and the new right column is {lb2[c], lb1[c], in_pixel}, read before the write.
- Output condition: out_valid is asserted one cycle after acceptance iff the accepted pixel has row>=2 and col>=2.
  - In that case out_row = row-1 and out_col = col-1.
  - Latency: exactly 1 clock from the accepting edge.
- Row-boundary windows: windows at col 0 and col 1 of any row are suppressed, because the shift array still holds the previous row's columns.
- Stale data: rows 0 and 1 of a frame never emit. After reset or SOF, stale line-buffer data is therefore never output.
- frame_done: asserted with the window whose accepted pixel is (IMG_H-1, IMG_W-1).
- Window count: exactly (IMG_W-2)*(IMG_H-2) windows per complete frame.
- Hold behaviour: outputs hold their values when out_valid=0. Consumers must qualify with out_valid.
- Reset during operation: reset takes priority over in_valid/in_sof in the same cycle. That pixel is dropped and out_valid=0 on the next cycle.

Test Plan:
- IMG_W=4, IMG_H=4, continuous in_valid, first pixel with in_sof, pixel value = 16*r+c:
  - The first out_valid is the cycle after the 11th accepted pixel (2,2).
  - Required window: px_1..px_9 = 00,01,02,10,11,12,20,21,22; out_row=1, out_col=1.
  - Exactly 4 windows, centres (1,1),(1,2),(2,1),(2,2); frame_done only with (2,2).
- Same frame with in_valid toggled 1,0,1,0: the window values and order are identical to the continuous run, and out_valid never asserts on two consecutive cycles.
- Two back-to-back frames without a gap, the second frame with values +0x80:
  - The second frame's first window is 80,81,82,90,91,92,A0,A1,A2.
  - No window is emitted during the second frame's rows 0 and 1.
- SOF asserted mid-frame at pixel (2,1) of frame A, then a full frame B: no window ever contains frame-A data, and the first window after the SOF is B's (1,1).
- rst=1 for one cycle mid-row-2, then a fresh SOF frame:
  - All outputs read 0 the cycle after reset.
  - The following frame's windows match the first scenario exactly.
- Default 640x480, random pixels: compare the windows against a software model, expecting 638*478 = 304964 windows.
